// File: rtl/nn_mem_loader.sv
// nn_mem_loader: stream-to-BRAM loader for one framed network image.
// A frame is a little-endian header word N, N payload words and a trailer word
// holding the modulo-2^DATA_LEN sum of the payload. Payload word i is written to
// BRAM address BASE_ADDR + i. done_o pulses at frame end, and error_o reports a
// rejected length or a checksum mismatch.
// Ports:
//   clk_i, reset_i       clock, asynchronous active-low reset
//   s_data_i/s_valid_i   input byte stream; s_ready_o accepts it
//   wr_ena_o/addr/data   BRAM write port (one-cycle strobe)
//   busy_o, done_o       frame in progress, end-of-frame pulse
//   error_o              sticky frame error, cleared by the next frame's first byte
//   words_o              payload words written in the current or last frame
module nn_mem_loader #(
    parameter int unsigned ADDR_LEN  = 2**16,
    parameter int unsigned DATA_LEN  = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [7:0]                  s_data_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    output logic                        wr_ena_o,
    output logic [$clog2(ADDR_LEN)-1:0] wr_addr_o,
    output logic [DATA_LEN-1:0]         wr_data_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [$clog2(ADDR_LEN):0]   words_o
);

    localparam int unsigned AW   = $clog2(ADDR_LEN);
    localparam int unsigned AW1  = AW + 1;
    localparam int unsigned BPW  = DATA_LEN / 8;
    localparam int unsigned CNTW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned CW   = (DATA_LEN > AW1) ? DATA_LEN : AW1;
    localparam logic [AW1-1:0]  LIMIT    = AW1'(ADDR_LEN - BASE_ADDR);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BPW - 1);

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        CSUM    = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [DATA_LEN-1:0] asm_q, asm_d;
    logic [DATA_LEN-1:0] sum_q, sum_d;
    logic [AW1-1:0]      n_q, n_d;
    logic [AW1-1:0]      words_q, words_d;
    logic                wr_ena_q, wr_ena_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_LEN-1:0] wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                ready_q, ready_d;

    logic                hs_c;
    logic                last_c;
    logic [DATA_LEN-1:0] word_c;
    logic [AW1-1:0]      words_inc_c;
    logic                bad_len_c;

    assign hs_c   = s_valid_i & ready_q;
    assign last_c = (cnt_q == CNT_LAST);
    // New byte enters at the top and older bytes move down, so after BPW bytes
    // the first byte of the word sits in bits [7:0].
    assign word_c      = DATA_LEN'({s_data_i, asm_q} >> 8);
    assign words_inc_c = words_q + AW1'(1);
    assign bad_len_c   = (word_c == '0) || (CW'(word_c) > CW'(LIMIT));

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        sum_d     = sum_q;
        n_d       = n_q;
        words_d   = words_q;
        wr_ena_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        error_d   = error_q;

        if (hs_c) begin
            asm_d = word_c;
            cnt_d = last_c ? '0 : cnt_q + CNTW'(1);
        end

        case (state_q)
            HDR: begin
                if (hs_c) begin
                    // First byte of a frame opens it; a rejection below may re-set error.
                    if (cnt_q == '0) begin
                        busy_d  = 1'b1;
                        error_d = 1'b0;
                        words_d = '0;
                    end
                    if (last_c) begin
                        if (bad_len_c) begin
                            error_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            n_d     = AW1'(word_c);
                            sum_d   = '0;
                            state_d = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (hs_c && last_c) begin
                    wr_ena_d  = 1'b1;
                    wr_addr_d = AW'(BASE_ADDR) + AW'(words_q);
                    wr_data_d = word_c;
                    sum_d     = sum_q + word_c;
                    words_d   = words_inc_c;
                    if (words_inc_c == n_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (hs_c && last_c) begin
                    if (word_c != sum_q) begin
                        error_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = HDR;
            end
            default: begin
                state_d = HDR;
            end
        endcase

        // The DONE cycle is flagged by registered outputs derived from the next state.
        if (state_d == DONE) begin
            busy_d = 1'b0;
        end
        done_d  = (state_d == DONE);
        ready_d = (state_d != DONE);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= HDR;
            cnt_q     <= '0;
            asm_q     <= '0;
            sum_q     <= '0;
            n_q       <= '0;
            words_q   <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            sum_q     <= sum_d;
            n_q       <= n_d;
            words_q   <= words_d;
            wr_ena_q  <= wr_ena_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ready_q   <= ready_d;
        end
    end

    assign s_ready_o = ready_q;
    assign wr_ena_o  = wr_ena_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign words_o   = words_q;

endmodule

// File: tb/tb_nn_mem_loader.sv
// Directed bench for nn_mem_loader: instance a at BASE_ADDR 0, instance b at
// BASE_ADDR 0xFFFE for the length limit. Both share clock and reset.
module tb_nn_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic        a_wena, b_wena;
    logic [15:0] a_waddr, b_waddr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_busy, b_busy, a_done, b_done, a_err, b_err;
    logic [16:0] a_words, b_words;

    nn_mem_loader #(.ADDR_LEN(65536), .DATA_LEN(32), .BASE_ADDR(0)) dut_a (
        .clk_i(clk), .reset_i(rst_n), .s_data_i(a_data), .s_valid_i(a_valid),
        .s_ready_o(a_ready), .wr_ena_o(a_wena), .wr_addr_o(a_waddr), .wr_data_o(a_wdata),
        .busy_o(a_busy), .done_o(a_done), .error_o(a_err), .words_o(a_words)
    );

    nn_mem_loader #(.ADDR_LEN(65536), .DATA_LEN(32), .BASE_ADDR(32'hFFFE)) dut_b (
        .clk_i(clk), .reset_i(rst_n), .s_data_i(b_data), .s_valid_i(b_valid),
        .s_ready_o(b_ready), .wr_ena_o(b_wena), .wr_addr_o(b_waddr), .wr_data_o(b_wdata),
        .busy_o(b_busy), .done_o(b_done), .error_o(b_err), .words_o(b_words)
    );

    int checks = 0;
    int passes = 0;
    int hold_viol = 0;
    int ready_viol = 0;
    bit armed = 1'b0;
    logic a_prev = 1'b0, b_prev = 1'b0;
    logic [15:0] a_wa[$], b_wa[$];
    logic [31:0] a_wd[$], b_wd[$];
    logic [31:0] nom[3];

    // Write logger and protocol watchers, sampled away from the rising edge
    always @(negedge clk) begin
        if (a_wena) begin a_wa.push_back(a_waddr); a_wd.push_back(a_wdata); end
        if (b_wena) begin b_wa.push_back(b_waddr); b_wd.push_back(b_wdata); end
        if ((a_wena && a_prev) || (b_wena && b_prev)) hold_viol <= hold_viol + 1;
        a_prev <= a_wena;
        b_prev <= b_wena;
        if (armed && ((!a_ready && !a_done) || (!b_ready && !b_done)))
            ready_viol <= ready_viol + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offers one byte from a falling edge and returns on the falling edge after the handshake.
    task automatic send_byte(input bit hi, input logic [7:0] b);
        int t;
        t = 0;
        if (hi) begin b_valid = 1'b1; b_data = b; end
        else    begin a_valid = 1'b1; a_data = b; end
        while (((hi ? b_ready : a_ready) !== 1'b1) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 64'(hi ? b_ready : a_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic send_word(input bit hi, input logic [31:0] w, input int gap2, input bit rnd);
        for (int i = 0; i < 4; i++) begin
            if (rnd) idle(int'($urandom_range(0, 2)));
            if (i == 2) idle(gap2);
            send_byte(hi, w[8*i +: 8]);
        end
    endtask

    task automatic send_frame(input bit hi, input int n, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] trl, input bit rnd, input int gap2);
        logic [31:0] pw[3];
        pw[0] = w0; pw[1] = w1; pw[2] = w2;
        send_word(hi, 32'(n), 0, rnd);
        for (int i = 0; i < n; i++) send_word(hi, pw[i], gap2, rnd);
        send_word(hi, trl, 0, rnd);
    endtask

    task automatic chk_nominal_writes(input string tag);
        chk({tag, "_count"}, 64'(a_wa.size()), 64'd3);
        for (int i = 0; i < 3 && i < a_wa.size(); i++) begin
            chk({tag, "_addr"}, 64'(a_wa[i]), 64'(i));
            chk({tag, "_data"}, 64'(a_wd[i]), 64'(nom[i]));
        end
    endtask

    task automatic chk_done_a(input string tag, input logic err, input int words);
        chk({tag, "_done"},  64'(a_done),  64'd1);
        chk({tag, "_err"},   64'(a_err),   64'(err));
        chk({tag, "_words"}, 64'(a_words), 64'(words));
        chk({tag, "_busy"},  64'(a_busy),  64'd0);
        chk({tag, "_ready"}, 64'(a_ready), 64'd0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 64'(a_done),  64'd0);
        chk({tag, "_ready_back"}, 64'(a_ready), 64'd1);
    endtask

    task automatic clear_logs();
        a_wa.delete(); a_wd.delete(); b_wa.delete(); b_wd.delete();
    endtask

    initial begin
        nom[0] = 32'h3F80_0000;
        nom[1] = 32'h4000_0000;
        nom[2] = 32'h4040_0000;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;

        // Reset values appear asynchronously
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_wena",  64'(a_wena),  64'd0);
        chk("rst_busy",  64'(a_busy),  64'd0);
        chk("rst_done",  64'(a_done),  64'd0);
        chk("rst_err",   64'(a_err),   64'd0);
        chk("rst_words", 64'(a_words), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(a_ready), 64'd1);
        armed = 1'b1;

        // Nominal frame, first write checked at its exact cycle
        send_word(1'b0, 32'd3, 0, 1'b0);
        chk("nom_busy", 64'(a_busy), 64'd1);
        send_word(1'b0, nom[0], 0, 1'b0);
        chk("nom_w0_ena",   64'(a_wena),  64'd1);
        chk("nom_w0_addr",  64'(a_waddr), 64'd0);
        chk("nom_w0_data",  64'(a_wdata), 64'h3F80_0000);
        chk("nom_w0_words", 64'(a_words), 64'd1);
        send_word(1'b0, nom[1], 0, 1'b0);
        send_word(1'b0, nom[2], 0, 1'b0);
        send_word(1'b0, 32'hBFC0_0000, 0, 1'b0);
        chk_done_a("nom", 1'b0, 3);
        chk_nominal_writes("nom");
        clear_logs();

        // Bad checksum: writes still land, error reported
        send_frame(1'b0, 3, nom[0], nom[1], nom[2], 32'h0, 1'b0, 0);
        chk_done_a("badsum", 1'b1, 3);
        chk_nominal_writes("badsum");
        clear_logs();

        // Following valid frame clears error on its first byte
        send_byte(1'b0, 8'h03);
        chk("clr_err",   64'(a_err),   64'd0);
        chk("clr_busy",  64'(a_busy),  64'd1);
        chk("clr_words", 64'(a_words), 64'd0);
        send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) send_word(1'b0, nom[i], 0, 1'b0);
        send_word(1'b0, 32'hBFC0_0000, 0, 1'b0);
        chk_done_a("recover", 1'b0, 3);
        chk_nominal_writes("recover");
        clear_logs();

        // Length rejection at BASE_ADDR 0xFFFE: header 3 exceeds the 2 free words
        send_byte(1'b1, 8'h03); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
        chk("len3_not_done_yet", 64'(b_done), 64'd0);
        send_byte(1'b1, 8'h00);
        chk("len3_done",  64'(b_done),  64'd1);
        chk("len3_err",   64'(b_err),   64'd1);
        chk("len3_words", 64'(b_words), 64'd0);
        @(negedge clk);
        chk("len3_done_1cyc", 64'(b_done), 64'd0);
        send_word(1'b1, 32'd0, 0, 1'b0);
        chk("len0_done", 64'(b_done), 64'd1);
        chk("len0_err",  64'(b_err),  64'd1);
        @(negedge clk);
        chk("len_nowrites", 64'(b_wa.size()), 64'd0);

        // Exactly-fitting length is accepted and fills the last two addresses
        send_frame(1'b1, 2, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0, 0);
        chk("fit_done",  64'(b_done),  64'd1);
        chk("fit_err",   64'(b_err),   64'd0);
        chk("fit_words", 64'(b_words), 64'd2);
        chk("fit_count", 64'(b_wa.size()), 64'd2);
        if (b_wa.size() == 2) begin
            chk("fit_addr0", 64'(b_wa[0]), 64'hFFFE);
            chk("fit_data0", 64'(b_wd[0]), 64'd1);
            chk("fit_addr1", 64'(b_wa[1]), 64'hFFFF);
            chk("fit_data1", 64'(b_wd[1]), 64'd2);
        end
        clear_logs();
        @(negedge clk);

        // Backpressure: random gaps plus a long gap between bytes 2 and 3 of each word
        send_frame(1'b0, 3, nom[0], nom[1], nom[2], 32'hBFC0_0000, 1'b1, 3);
        chk_done_a("bp", 1'b0, 3);
        chk_nominal_writes("bp");
        clear_logs();

        // Reset after 6 payload bytes (word 0 plus half of word 1)
        send_word(1'b0, 32'd3, 0, 1'b0);
        send_word(1'b0, nom[0], 0, 1'b0);
        send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h00);
        chk("mid_busy_before", 64'(a_busy), 64'd1);
        armed = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ready", 64'(a_ready), 64'd0);
        chk("mid_wena",  64'(a_wena),  64'd0);
        chk("mid_addr",  64'(a_waddr), 64'd0);
        chk("mid_data",  64'(a_wdata), 64'd0);
        chk("mid_busy",  64'(a_busy),  64'd0);
        chk("mid_done",  64'(a_done),  64'd0);
        chk("mid_err",   64'(a_err),   64'd0);
        chk("mid_words", 64'(a_words), 64'd0);
        chk("mid_writes_before", 64'(a_wa.size()), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        armed = 1'b1;
        clear_logs();
        send_frame(1'b0, 3, nom[0], nom[1], nom[2], 32'hBFC0_0000, 1'b0, 0);
        chk_done_a("post_rst", 1'b0, 3);
        chk_nominal_writes("post_rst");

        idle(2);
        chk("wena_single_cycle", 64'(hold_viol), 64'd0);
        chk("ready_low_only_done", 64'(ready_viol), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
